// File: rtl/seq_load_txn_gen_if.sv
// Bus bundle for seq_load_txn_gen: request input, AXI4 AR channel and the
// per-beat transaction-control stream. Signal suffixes are written from the
// generator's point of view.
//   master : generator side (seq_load_txn_gen)
//   slave  : environment side (request source, AR sink, beat consumer)
interface seq_load_txn_gen_if #(
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned LenWidth     = 32
) ();
  localparam int unsigned NibW = $clog2(AxiDataWidth / 4);

  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [AxiAddrWidth-1:0] req_addr_i;
  logic [LenWidth-1:0]     req_nbytes_i;

  logic                    ar_valid_o;
  logic                    ar_ready_i;
  logic [AxiAddrWidth-1:0] ar_addr_o;
  logic [7:0]              ar_len_o;
  logic [2:0]              ar_size_o;
  logic [1:0]              ar_burst_o;

  logic                    txn_valid_o;
  logic                    txn_ready_i;
  logic [NibW-1:0]         txn_addr_o;
  logic                    txn_is_head_o;
  logic [7:0]              txn_rmn_beat_o;
  logic [NibW:0]           txn_lbn_o;
  logic                    txn_is_final_o;

  logic                    busy_o;

  modport master (
    input  req_valid_i, req_addr_i, req_nbytes_i, ar_ready_i, txn_ready_i,
    output req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o,
    output txn_valid_o, txn_addr_o, txn_is_head_o, txn_rmn_beat_o, txn_lbn_o,
    output txn_is_final_o, busy_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_nbytes_i, ar_ready_i, txn_ready_i,
    input  req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o,
    input  txn_valid_o, txn_addr_o, txn_is_head_o, txn_rmn_beat_o, txn_lbn_o,
    input  txn_is_final_o, busy_o
  );
endinterface

// File: rtl/seq_load_txn_gen.sv
// Sequential load transaction generator.
// Takes one unit-stride load request (byte address + byte count), splits it
// into AXI4 INCR read bursts that never cross a 4 KiB page nor exceed
// MaxBurstBeats, drives the AR channel, and for each issued burst emits one
// control record per R beat for the downstream load data controller.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset
//   bus_io  request / AR / per-beat control bundle (master side)
module seq_load_txn_gen #(
  parameter int unsigned AxiDataWidth  = 128,
  parameter int unsigned AxiAddrWidth  = 64,
  parameter int unsigned LenWidth      = 32,
  parameter int unsigned MaxBurstBeats = 256,
  parameter int unsigned TxnQueueDepth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  seq_load_txn_gen_if.master  bus_io
);
  localparam int unsigned BusBytes   = AxiDataWidth / 8;
  localparam int unsigned BusNibbles = AxiDataWidth / 4;
  localparam int unsigned OffW       = $clog2(BusBytes);
  localparam int unsigned NibW       = $clog2(BusNibbles);
  localparam int unsigned PtrW       = $clog2(TxnQueueDepth);
  // Burst-size arithmetic width: wide enough for the request length and
  // for a full 4 KiB / max-burst byte count.
  localparam int unsigned CW         = (LenWidth > 32) ? LenWidth : 32;
  // Descriptor: {nibble offset, len (beats-1), lbn, final}
  localparam int unsigned DescW      = NibW + 8 + (NibW + 1) + 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [AxiAddrWidth-1:0] cur_addr_q, cur_addr_d;
  logic [LenWidth-1:0]     rmn_q, rmn_d;
  logic [PtrW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic [DescW-1:0]        mem_q [TxnQueueDepth];

  // ---------------------------------------------------------------------------
  // Burst calculation for the current split position
  // ---------------------------------------------------------------------------
  logic [OffW-1:0] off;
  logic [OffW-1:0] last_off;
  logic [OffW:0]   last_cnt;
  logic [CW-1:0]   to4k, cap, lim, rmn_ext, bytes, span;
  logic [7:0]      burst_len;
  logic [NibW:0]   burst_lbn;
  logic            burst_final;

  always_comb begin
    off         = cur_addr_q[OffW-1:0];
    to4k        = CW'(13'd4096) - CW'(cur_addr_q[11:0]);
    cap         = CW'(MaxBurstBeats * BusBytes) - CW'(off);
    lim         = (to4k < cap) ? to4k : cap;
    rmn_ext     = CW'(rmn_q);
    bytes       = (rmn_ext < lim) ? rmn_ext : lim;
    // beats - 1 = floor((off + bytes - 1) / busBytes); bytes >= 1 in ISSUE
    span        = CW'(off) + bytes - CW'(1);
    burst_len   = 8'(span >> OffW);
    // Byte index of the last valid byte within its beat, mod busBytes
    last_off    = off + bytes[OffW-1:0] - OffW'(1);
    last_cnt    = {1'b0, last_off} + (OffW + 1)'(1);
    burst_lbn   = {last_cnt, 1'b0};
    burst_final = (rmn_ext == bytes);
  end

  // ---------------------------------------------------------------------------
  // Descriptor FIFO status (registered pointers only)
  // ---------------------------------------------------------------------------
  logic fifo_empty, fifo_full;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  logic in_issue, ar_valid, ar_hs;
  assign in_issue = (state_q == StIssue);
  assign ar_valid = in_issue && !fifo_full;
  assign ar_hs    = ar_valid && bus_io.ar_ready_i;

  logic [DescW-1:0] push_desc;
  assign push_desc = {{off, 1'b0}, burst_len, burst_lbn, burst_final};

  // ---------------------------------------------------------------------------
  // Split FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rmn_d      = rmn_q;
    case (state_q)
      StIdle: begin
        // Zero-length requests are accepted and dropped
        if (bus_io.req_valid_i && (bus_io.req_nbytes_i != '0)) begin
          cur_addr_d = bus_io.req_addr_i;
          rmn_d      = bus_io.req_nbytes_i;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (ar_hs) begin
          cur_addr_d = cur_addr_q + AxiAddrWidth'(bytes);
          rmn_d      = rmn_q - LenWidth'(bytes);
          if (burst_final) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat emitter
  // ---------------------------------------------------------------------------
  logic [NibW-1:0] h_addr;
  logic [7:0]      h_len;
  logic [NibW:0]   h_lbn;
  logic            h_final;
  logic [7:0]      rmn_beat;
  logic            txn_hs, txn_last;

  assign {h_addr, h_len, h_lbn, h_final} = mem_q[rd_ptr_q[PtrW-1:0]];
  assign rmn_beat = h_len - beat_cnt_q;
  assign txn_hs   = !fifo_empty && bus_io.txn_ready_i;
  assign txn_last = (rmn_beat == 8'd0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (ar_hs) wr_ptr_d = wr_ptr_q + (PtrW + 1)'(1);
    if (txn_hs) begin
      if (txn_last) begin
        rd_ptr_d   = rd_ptr_q + (PtrW + 1)'(1);
        beat_cnt_d = 8'd0;
      end else begin
        beat_cnt_d = beat_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cur_addr_q <= '0;
      rmn_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rmn_q      <= rmn_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible while the FIFO is non-empty
  always_ff @(posedge clk_i) begin
    if (ar_hs) mem_q[wr_ptr_q[PtrW-1:0]] <= push_desc;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_io.req_ready_o    = (state_q == StIdle);
  assign bus_io.ar_valid_o     = ar_valid;
  assign bus_io.ar_addr_o      = in_issue ? cur_addr_q : '0;
  assign bus_io.ar_len_o       = in_issue ? burst_len : 8'd0;
  assign bus_io.ar_size_o      = 3'(OffW);
  assign bus_io.ar_burst_o     = 2'b01;

  assign bus_io.txn_valid_o    = !fifo_empty;
  assign bus_io.txn_is_head_o  = !fifo_empty && (beat_cnt_q == 8'd0);
  assign bus_io.txn_addr_o     = (!fifo_empty && (beat_cnt_q == 8'd0)) ? h_addr : '0;
  assign bus_io.txn_rmn_beat_o = fifo_empty ? 8'd0 : rmn_beat;
  assign bus_io.txn_lbn_o      = fifo_empty ? '0 : h_lbn;
  assign bus_io.txn_is_final_o = !fifo_empty && h_final;

  assign bus_io.busy_o         = (state_q != StIdle) || !fifo_empty;
endmodule

// File: tb/tb_seq_load_txn_gen.sv
module tb_seq_load_txn_gen;
  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct packed {
    logic       head;
    logic [4:0] addr;
    logic [7:0] rmn;
    logic [5:0] lbn;
    logic       fin;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_load_txn_gen_if #(.AxiDataWidth(128), .AxiAddrWidth(64), .LenWidth(32)) bus ();

  seq_load_txn_gen #(
    .AxiDataWidth (128),
    .AxiAddrWidth (64),
    .LenWidth     (32),
    .MaxBurstBeats(256),
    .TxnQueueDepth(4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   ar_cnt   = 0;
  int   txn_cnt  = 0;
  ar_t  exp_ar_q[$];
  ar_t  obs_ar_q[$];
  txn_t exp_txn_q[$];
  txn_t last_txn;

  // Reference split model: expected AR and per-beat records for one request
  function automatic void model_req(input longint unsigned addr, input longint unsigned nbytes);
    longint unsigned a = addr;
    longint unsigned r = nbytes;
    longint unsigned off, to4k, cap, b, beats, lbn;
    bit fin;
    ar_t  ea;
    txn_t et;
    while (r != 0) begin
      off   = a % 16;
      to4k  = 4096 - (a % 4096);
      cap   = 256 * 16 - off;
      b     = r;
      if (to4k < b) b = to4k;
      if (cap < b)  b = cap;
      beats = (off + b + 15) / 16;
      lbn   = (((a + b - 1) % 16) + 1) * 2;
      fin   = (r == b);
      ea.addr = a;
      ea.len  = 8'(beats - 1);
      exp_ar_q.push_back(ea);
      for (longint unsigned k = 0; k < beats; k++) begin
        et.head = (k == 0);
        et.addr = (k == 0) ? 5'(off * 2) : 5'd0;
        et.rmn  = 8'(beats - 1 - k);
        et.lbn  = 6'(lbn);
        et.fin  = fin;
        exp_txn_q.push_back(et);
      end
      a += b;
      r -= b;
    end
  endfunction

  // Scoreboard monitor: compares every AR / txn handshake, checks AR stability
  bit          stall_q = 0;
  logic [63:0] stall_addr;
  logic [7:0]  stall_len;
  always @(negedge clk) begin
    ar_t  got_ar, e_ar;
    txn_t got_t, e_t;
    if (rst) begin
      stall_q = 0;
    end else begin
      if (stall_q) begin
        checks++;
        if (bus.ar_valid_o !== 1'b1 || bus.ar_addr_o !== stall_addr || bus.ar_len_o !== stall_len) begin
          failures++;
          $display("FAIL ar_stable: valid=%0b addr=%h len=%0d, required valid=1 addr=%h len=%0d",
                   bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, stall_addr, stall_len);
        end
      end
      stall_q    = bus.ar_valid_o && !bus.ar_ready_i;
      stall_addr = bus.ar_addr_o;
      stall_len  = bus.ar_len_o;

      if (bus.ar_valid_o && bus.ar_ready_i) begin
        got_ar.addr = bus.ar_addr_o;
        got_ar.len  = bus.ar_len_o;
        obs_ar_q.push_back(got_ar);
        ar_cnt++;
        checks++;
        if (exp_ar_q.size() == 0) begin
          failures++;
          $display("FAIL ar_unexpected: addr=%h len=%0d, required no AR", got_ar.addr, got_ar.len);
        end else begin
          e_ar = exp_ar_q.pop_front();
          if (got_ar !== e_ar || bus.ar_size_o !== 3'd4 || bus.ar_burst_o !== 2'b01) begin
            failures++;
            $display("FAIL ar_beat: addr=%h len=%0d size=%0d burst=%0d, required addr=%h len=%0d size=4 burst=1",
                     got_ar.addr, got_ar.len, bus.ar_size_o, bus.ar_burst_o, e_ar.addr, e_ar.len);
          end
        end
      end

      if (bus.txn_valid_o && bus.txn_ready_i) begin
        got_t.head = bus.txn_is_head_o;
        got_t.addr = bus.txn_addr_o;
        got_t.rmn  = bus.txn_rmn_beat_o;
        got_t.lbn  = bus.txn_lbn_o;
        got_t.fin  = bus.txn_is_final_o;
        last_txn   = got_t;
        txn_cnt++;
        checks++;
        if (exp_txn_q.size() == 0) begin
          failures++;
          $display("FAIL txn_unexpected: head=%0b addr=%0d rmn=%0d, required no beat",
                   got_t.head, got_t.addr, got_t.rmn);
        end else begin
          e_t = exp_txn_q.pop_front();
          if (got_t !== e_t) begin
            failures++;
            $display("FAIL txn_beat %0d: head=%0b addr=%0d rmn=%0d lbn=%0d fin=%0b, required head=%0b addr=%0d rmn=%0d lbn=%0d fin=%0b",
                     txn_cnt, got_t.head, got_t.addr, got_t.rmn, got_t.lbn, got_t.fin,
                     e_t.head, e_t.addr, e_t.rmn, e_t.lbn, e_t.fin);
          end
        end
      end
    end
  end

  task automatic clear_obs();
    ar_cnt  = 0;
    txn_cnt = 0;
    obs_ar_q.delete();
  endtask

  task automatic send_req(input logic [63:0] a, input logic [31:0] n);
    bit ok = 0;
    bus.req_addr_i   = a;
    bus.req_nbytes_i = n;
    bus.req_valid_i  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.req_ready_o === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL req_accept: req_ready stayed 0, required 1");
    end else begin
      model_req(a, n);
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit ok = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!bus.busy_o && exp_ar_q.size() == 0 && exp_txn_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s drain: busy=%0b ar_left=%0d txn_left=%0d, required 0 0 0",
               tag, bus.busy_o, exp_ar_q.size(), exp_txn_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_nbytes_i = '0;
    bus.ar_ready_i   = 1'b1;
    bus.txn_ready_i  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 1'b1 || bus.ar_valid_o !== 1'b0 || bus.txn_valid_o !== 1'b0 ||
        bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: rdy=%0b arv=%0b txv=%0b busy=%0b, required 1 0 0 0",
               bus.req_ready_o, bus.ar_valid_o, bus.txn_valid_o, bus.busy_o);
    end
    checks++;
    if (bus.ar_addr_o !== 64'd0 || bus.ar_len_o !== 8'd0 || bus.txn_lbn_o !== 6'd0 ||
        bus.ar_size_o !== 3'd4 || bus.ar_burst_o !== 2'b01) begin
      failures++;
      $display("FAIL reset_data: addr=%h len=%0d lbn=%0d size=%0d burst=%0d, required 0 0 0 4 1",
               bus.ar_addr_o, bus.ar_len_o, bus.txn_lbn_o, bus.ar_size_o, bus.ar_burst_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    clear_obs();
    send_req(64'h1004, 32'd40);
    drain("basic");
    checks++;
    if (ar_cnt != 1 || txn_cnt != 3 || obs_ar_q.size() != 1) begin
      failures++;
      $display("FAIL basic_counts: ars=%0d beats=%0d, required 1 3", ar_cnt, txn_cnt);
    end else begin
      checks++;
      if (obs_ar_q[0].addr !== 64'h1004 || obs_ar_q[0].len !== 8'd2 ||
          last_txn.lbn !== 6'd24 || last_txn.fin !== 1'b1 || last_txn.rmn !== 8'd0) begin
        failures++;
        $display("FAIL basic_vals: addr=%h len=%0d lbn=%0d fin=%0b, required 1004 2 24 1",
                 obs_ar_q[0].addr, obs_ar_q[0].len, last_txn.lbn, last_txn.fin);
      end
    end
  endtask

  task automatic test_4k_cross();
    clear_obs();
    send_req(64'h0FF8, 32'd32);
    drain("4k_cross");
    checks++;
    if (ar_cnt != 2 || txn_cnt != 3 || obs_ar_q.size() != 2) begin
      failures++;
      $display("FAIL 4k_counts: ars=%0d beats=%0d, required 2 3", ar_cnt, txn_cnt);
    end else begin
      checks++;
      if (obs_ar_q[0].addr !== 64'h0FF8 || obs_ar_q[0].len !== 8'd0 ||
          obs_ar_q[1].addr !== 64'h1000 || obs_ar_q[1].len !== 8'd1) begin
        failures++;
        $display("FAIL 4k_ars: %h/%0d %h/%0d, required 0ff8/0 1000/1",
                 obs_ar_q[0].addr, obs_ar_q[0].len, obs_ar_q[1].addr, obs_ar_q[1].len);
      end
    end
  endtask

  task automatic test_long_backpressure();
    bit done = 0;
    clear_obs();
    fork
      begin
        send_req(64'h0, 32'd5000);
        drain("long");
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.ar_ready_i  = 1'($urandom_range(0, 1));
          bus.txn_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.ar_ready_i  = 1'b1;
    bus.txn_ready_i = 1'b1;
    checks++;
    if (ar_cnt != 2 || txn_cnt != 313 || obs_ar_q.size() != 2) begin
      failures++;
      $display("FAIL long_counts: ars=%0d beats=%0d, required 2 313", ar_cnt, txn_cnt);
    end else begin
      checks++;
      if (obs_ar_q[0].len !== 8'd255 || obs_ar_q[1].addr !== 64'h1000 ||
          obs_ar_q[1].len !== 8'd56 || last_txn.lbn !== 6'd16) begin
        failures++;
        $display("FAIL long_vals: len0=%0d addr1=%h len1=%0d lbn=%0d, required 255 1000 56 16",
                 obs_ar_q[0].len, obs_ar_q[1].addr, obs_ar_q[1].len, last_txn.lbn);
      end
    end
  endtask

  task automatic test_fifo_full_stall();
    bit ok = 0;
    clear_obs();
    bus.txn_ready_i = 1'b0;
    bus.ar_ready_i  = 1'b1;
    send_req(64'h0, 32'd24576);
    repeat (20) @(negedge clk);
    checks++;
    if (ar_cnt != 4 || bus.ar_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL full_block: ars=%0d arv=%0b, required 4 0", ar_cnt, bus.ar_valid_o);
    end
    @(posedge clk);
    #1;
    bus.ar_ready_i  = 1'b0;
    bus.txn_ready_i = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (txn_cnt >= 256) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.txn_ready_i = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL full_drain: beats=%0d, required 256", txn_cnt);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus.ar_valid_o !== 1'b1 || bus.ar_addr_o !== 64'h4000 || bus.ar_len_o !== 8'd255) begin
        failures++;
        $display("FAIL fifth_ar: arv=%0b addr=%h len=%0d, required 1 4000 255",
                 bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o);
      end
    end
    @(posedge clk);
    #1;
    bus.ar_ready_i  = 1'b1;
    bus.txn_ready_i = 1'b1;
    drain("stall");
    checks++;
    if (ar_cnt != 6 || txn_cnt != 1536) begin
      failures++;
      $display("FAIL stall_counts: ars=%0d beats=%0d, required 6 1536", ar_cnt, txn_cnt);
    end
  endtask

  task automatic test_zero_len();
    clear_obs();
    send_req(64'h2000, 32'd0);
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.busy_o !== 1'b0 || bus.ar_valid_o !== 1'b0 || bus.txn_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL zero_len: busy=%0b arv=%0b txv=%0b, required 0 0 0",
                 bus.busy_o, bus.ar_valid_o, bus.txn_valid_o);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (ar_cnt != 0 || txn_cnt != 0) begin
      failures++;
      $display("FAIL zero_counts: ars=%0d beats=%0d, required 0 0", ar_cnt, txn_cnt);
    end
  endtask

  task automatic test_mid_reset();
    bit ok = 0;
    clear_obs();
    send_req(64'h0, 32'd8192);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (txn_cnt >= 10) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midrst_progress: beats=%0d, required >=10", txn_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_ar_q.delete();
    exp_txn_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 1'b1 || bus.ar_valid_o !== 1'b0 || bus.txn_valid_o !== 1'b0 ||
        bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL midrst_state: rdy=%0b arv=%0b txv=%0b busy=%0b, required 1 0 0 0",
               bus.req_ready_o, bus.ar_valid_o, bus.txn_valid_o, bus.busy_o);
    end
    @(posedge clk);
    #1;
    clear_obs();
    send_req(64'h1004, 32'd40);
    drain("after_reset");
    checks++;
    if (ar_cnt != 1 || txn_cnt != 3) begin
      failures++;
      $display("FAIL midrst_fresh: ars=%0d beats=%0d, required 1 3", ar_cnt, txn_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_4k_cross();
    test_long_backpressure();
    test_fifo_full_stall();
    test_zero_len();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
